// File: rtl/rggen_apb_adapter.sv
// APB slave front end for a set of generated registers.
// Captures one APB transfer, presents it to the registers as a single held
// request, OR-reduces the register responses and returns them in one cycle.
//
//   state    | meaning
//   IDLE     | waiting for an APB setup phase
//   BUSY     | request presented to the registers, waiting for a response
//   RESPONSE | pready driven for exactly one cycle with the latched result
//
// BUS_WIDTH is expected to be 32 or 64 and REGISTERS at least 1.
module rggen_apb_adapter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int REGISTERS     = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
  input  logic                           i_pwrite,
  input  logic [BUS_WIDTH-1:0]           i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
  output logic                           o_pready,
  output logic [BUS_WIDTH-1:0]           o_prdata,
  output logic                           o_pslverr,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BUSY     = 2'b01,
    RESPONSE = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDRESS_WIDTH-1:0] address_q;
  logic                     write_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [STRB_WIDTH-1:0]    strobe_q;
  logic [BUS_WIDTH-1:0]     read_data_q;
  logic [1:0]               status_q;

  logic                     setup;
  logic [REGISTERS-1:0]     hit;
  logic                     no_active;
  logic                     response_ready;
  logic [BUS_WIDTH-1:0]     read_data_reduced;
  logic [1:0]               status_reduced;

  // A setup phase is only recognised while idle; an access phase seen in
  // IDLE belongs to nobody and is dropped.
  assign setup          = (state == IDLE) && i_psel && !i_penable;
  assign hit            = i_register_active & i_register_ready;
  assign no_active      = (i_register_active == '0);
  assign response_ready = (|hit) || no_active;

  // OR-reduce the responses of every register that is both hit and ready.
  // Several active registers is a system error and is returned as-is.
  always_comb begin
    read_data_reduced = '0;
    status_reduced    = 2'b00;
    for (int i = 0; i < REGISTERS; i++) begin
      if (hit[i]) begin
        read_data_reduced = read_data_reduced | i_register_read_data[i*BUS_WIDTH +: BUS_WIDTH];
        status_reduced    = status_reduced | i_register_status[2*i +: 2];
      end
    end
    if (no_active) begin
      read_data_reduced = '0;
      status_reduced    = 2'b11;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; BUSY waits indefinitely for the registers.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (setup) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (response_ready) begin
          state_next = RESPONSE;
        end
      end
      RESPONSE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request on the setup phase. Reads present a full strobe and
  // zero write data so the registers never see stale write values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      address_q    <= '0;
      write_q      <= 1'b0;
      write_data_q <= '0;
      strobe_q     <= '0;
    end else if (setup) begin
      address_q    <= i_paddr;
      write_q      <= i_pwrite;
      write_data_q <= i_pwrite ? i_pwdata : '0;
      strobe_q     <= i_pwrite ? i_pstrb : '1;
    end
  end

  // Latch the reduced response on the edge that leaves BUSY.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      read_data_q <= '0;
      status_q    <= 2'b00;
    end else if ((state == BUSY) && response_ready) begin
      read_data_q <= read_data_reduced;
      status_q    <= status_reduced;
    end
  end

  // Output decode: request side only in BUSY, APB response only in RESPONSE.
  always_comb begin
    o_register_valid      = (state == BUSY);
    o_register_access     = {1'b0, write_q};
    o_register_address    = address_q;
    o_register_write_data = write_data_q;
    o_register_strobe     = strobe_q;
    o_pready              = 1'b0;
    o_pslverr             = 1'b0;
    o_prdata              = '0;
    if (state == RESPONSE) begin
      o_pready  = 1'b1;
      o_pslverr = status_q[1];
      o_prdata  = write_q ? '0 : read_data_q;
    end
  end

endmodule

// File: tb/tb_rggen_apb_adapter.sv
// Scoreboard bench for rggen_apb_adapter with two attached registers.
module tb_rggen_apb_adapter;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int NR = 2;
  localparam int SW = BW / 8;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_psel;
  logic                 i_penable;
  logic [AW-1:0]        i_paddr;
  logic                 i_pwrite;
  logic [BW-1:0]        i_pwdata;
  logic [SW-1:0]        i_pstrb;
  logic                 o_pready;
  logic [BW-1:0]        o_prdata;
  logic                 o_pslverr;
  logic                 o_register_valid;
  logic [1:0]           o_register_access;
  logic [AW-1:0]        o_register_address;
  logic [BW-1:0]        o_register_write_data;
  logic [SW-1:0]        o_register_strobe;
  logic [NR-1:0]        i_register_active;
  logic [NR-1:0]        i_register_ready;
  logic [NR-1:0][1:0]   i_register_status;
  logic [NR-1:0][BW-1:0] i_register_read_data;

  always #5 i_clk = ~i_clk;

  rggen_apb_adapter #(
    .ADDRESS_WIDTH(AW),
    .BUS_WIDTH    (BW),
    .REGISTERS    (NR)
  ) dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_psel               (i_psel),
    .i_penable            (i_penable),
    .i_paddr              (i_paddr),
    .i_pwrite             (i_pwrite),
    .i_pwdata             (i_pwdata),
    .i_pstrb              (i_pstrb),
    .o_pready             (o_pready),
    .o_prdata             (o_prdata),
    .o_pslverr            (o_pslverr),
    .o_register_valid     (o_register_valid),
    .o_register_access    (o_register_access),
    .o_register_address   (o_register_address),
    .o_register_write_data(o_register_write_data),
    .o_register_strobe    (o_register_strobe),
    .i_register_active    (i_register_active),
    .i_register_ready     (i_register_ready),
    .i_register_status    (i_register_status),
    .i_register_read_data (i_register_read_data)
  );

  typedef struct {
    logic                  write;
    logic [AW-1:0]         addr;
    logic [BW-1:0]         wdata;
    logic [SW-1:0]         strb;
    logic [NR-1:0]         active;
    int                    delay;
    logic [NR-1:0][BW-1:0] rdata;
    logic [NR-1:0][1:0]    status;
  } xfer_t;

  typedef struct {
    logic [1:0]    access;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic [SW-1:0] strb;
    int            cycles;
  } req_t;

  typedef struct {
    logic          slverr;
    logic [BW-1:0] prdata;
  } rsp_t;

  req_t  req_q[$];
  rsp_t  rsp_q[$];
  xfer_t cur;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pready = 0;
  int n_issued = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the registers should see for a transfer.
  function automatic req_t model_req(input xfer_t t);
    req_t r;
    r.access = t.write ? 2'b01 : 2'b00;
    r.addr   = t.addr;
    r.wdata  = t.write ? t.wdata : '0;
    r.strb   = t.write ? t.strb : {SW{1'b1}};
    r.cycles = (t.active == '0) ? 1 : t.delay + 1;
    return r;
  endfunction

  // Reference model: what the APB master should get back. All active
  // registers become ready together in this bench.
  function automatic rsp_t model_rsp(input xfer_t t);
    rsp_t          r;
    logic [BW-1:0] data;
    logic [1:0]    st;
    data = '0;
    st   = 2'b00;
    if (t.active == '0) begin
      st = 2'b11;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (t.active[i]) begin
          data = data | t.rdata[i];
          st   = st | t.status[i];
        end
      end
    end
    r.slverr = st[1];
    r.prdata = t.write ? '0 : data;
    return r;
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t t;
    int    sel;
    t.write = 1'($urandom_range(0, 1));
    t.addr  = AW'($urandom);
    t.wdata = $urandom;
    t.strb  = SW'($urandom);
    sel     = $urandom_range(0, 9);
    if (sel == 0)      t.active = '0;
    else if (sel == 1) t.active = '1;
    else               t.active = NR'(1 << $urandom_range(0, NR - 1));
    t.delay = $urandom_range(0, 3);
    for (int i = 0; i < NR; i++) begin
      t.rdata[i]  = $urandom;
      t.status[i] = 2'($urandom);
    end
    return t;
  endfunction

  task automatic do_xfer(input xfer_t t);
    int budget;
    @(negedge i_clk);
    i_psel    = 1'b1;
    i_penable = 1'b0;
    i_paddr   = t.addr;
    i_pwrite  = t.write;
    i_pwdata  = t.wdata;
    i_pstrb   = t.strb;
    cur       = t;
    req_q.push_back(model_req(t));
    rsp_q.push_back(model_rsp(t));
    n_issued++;
    @(negedge i_clk);
    i_penable = 1'b1;
    budget = 0;
    while (!o_pready && budget < 50) begin
      @(negedge i_clk);
      budget++;
    end
    check("pready_within_budget", 64'(budget < 50), 64'(1));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_psel    = 1'b0;
      i_penable = 1'b0;
      i_pwdata  = $urandom;
    end
  endtask

  // Register responder: drives the per-register inputs while a request is
  // held; the active registers become ready after cur.delay BUSY cycles.
  initial begin
    int k;
    k = 0;
    i_register_active    = '0;
    i_register_ready     = '0;
    i_register_status    = '0;
    i_register_read_data = '0;
    forever begin
      @(negedge i_clk);
      if (o_register_valid) begin
        i_register_active    = cur.active;
        i_register_ready     = (k >= cur.delay) ? {NR{1'b1}} : (~cur.active & NR'($urandom));
        i_register_status    = cur.status;
        i_register_read_data = cur.rdata;
        k++;
      end else begin
        k = 0;
        i_register_active    = NR'($urandom);
        i_register_ready     = NR'($urandom);
        i_register_status    = (2*NR)'($urandom);
        i_register_read_data = {$urandom, $urandom};
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a request or response.
  initial begin
    logic prev_valid;
    int   vcnt;
    bit   have_req;
    req_t er;
    rsp_t es;
    prev_valid = 1'b0;
    vcnt       = 0;
    have_req   = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_register_valid) begin
        if (!prev_valid) begin
          check("req_queue_empty_on_valid", 64'(req_q.size() == 0), 64'(0));
          if (req_q.size() > 0) begin
            er = req_q.pop_front();
            have_req = 1'b1;
          end
          vcnt = 0;
        end
        vcnt++;
        if (have_req) begin
          check("register_access", 64'(o_register_access), 64'(er.access));
          check("register_address", 64'(o_register_address), 64'(er.addr));
          check("register_write_data", 64'(o_register_write_data), 64'(er.wdata));
          check("register_strobe", 64'(o_register_strobe), 64'(er.strb));
        end
        check("pready_during_valid", 64'(o_pready), 64'(0));
      end else if (prev_valid && have_req) begin
        check("valid_cycles", 64'(vcnt), 64'(er.cycles));
        have_req = 1'b0;
      end
      if (o_pready) begin
        n_pready++;
        check("pready_follows_valid", 64'(prev_valid), 64'(1));
        check("rsp_queue_empty_on_pready", 64'(rsp_q.size() == 0), 64'(0));
        if (rsp_q.size() > 0) begin
          es = rsp_q.pop_front();
          check("pslverr", 64'(o_pslverr), 64'(es.slverr));
          check("prdata", 64'(o_prdata), 64'(es.prdata));
        end
      end else begin
        check("idle_pslverr", 64'(o_pslverr), 64'(0));
        check("idle_prdata", 64'(o_prdata), 64'(0));
      end
      prev_valid = o_register_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    xfer_t t;
    i_rst     = 1'b1;
    i_psel    = 1'b0;
    i_penable = 1'b0;
    i_paddr   = '0;
    i_pwrite  = 1'b0;
    i_pwdata  = '0;
    i_pstrb   = '0;
    repeat (3) @(negedge i_clk);
    check("reset_valid", 64'(o_register_valid), 64'(0));
    check("reset_pready", 64'(o_pready), 64'(0));
    check("reset_access", 64'(o_register_access), 64'(0));
    check("reset_address", 64'(o_register_address), 64'(0));
    check("reset_write_data", 64'(o_register_write_data), 64'(0));
    check("reset_strobe", 64'(o_register_strobe), 64'(0));
    i_rst = 1'b0;
    idle_cycles(2);

    // Write 0x12345678 to 0x04, register 0 ready immediately, status OKAY.
    t = rand_xfer();
    t.write = 1'b1; t.addr = 8'h04; t.wdata = 32'h1234_5678; t.strb = 4'hF;
    t.active = 2'b01; t.delay = 0; t.status[0] = 2'b00;
    do_xfer(t);
    idle_cycles(1);

    // Read 0x08, register 1 ready after three BUSY cycles.
    t = rand_xfer();
    t.write = 1'b0; t.addr = 8'h08; t.active = 2'b10; t.delay = 2;
    t.rdata[1] = 32'hCAFE_F00D; t.status[1] = 2'b00;
    do_xfer(t);
    idle_cycles(1);

    // Read 0x3C with nothing decoding the address.
    t = rand_xfer();
    t.write = 1'b0; t.addr = 8'h3C; t.active = 2'b00;
    do_xfer(t);

    // Write that a register rejects with SLVERR.
    t = rand_xfer();
    t.write = 1'b1; t.active = 2'b01; t.delay = 1; t.status[0] = 2'b10;
    do_xfer(t);

    // Two back-to-back reads.
    t = rand_xfer(); t.write = 1'b0; t.active = 2'b01;
    do_xfer(t);
    t = rand_xfer(); t.write = 1'b0; t.active = 2'b10;
    do_xfer(t);

    // Access phase with no preceding setup must be ignored.
    @(negedge i_clk);
    i_psel = 1'b1; i_penable = 1'b1; i_paddr = 8'h55;
    @(negedge i_clk);
    check("no_capture_on_penable", 64'(o_register_valid), 64'(0));
    i_psel = 1'b0; i_penable = 1'b0;

    // Reset during BUSY abandons the transfer without a pready pulse.
    t = rand_xfer();
    t.write = 1'b1; t.active = 2'b01; t.delay = 1000;
    @(negedge i_clk);
    i_psel = 1'b1; i_penable = 1'b0; i_paddr = t.addr;
    i_pwrite = t.write; i_pwdata = t.wdata; i_pstrb = t.strb;
    cur = t;
    req_q.push_back(model_req(t));
    req_q[req_q.size()-1].cycles = 2;
    @(negedge i_clk);
    i_penable = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("abort_valid", 64'(o_register_valid), 64'(0));
    check("abort_pready", 64'(o_pready), 64'(0));
    check("abort_address", 64'(o_register_address), 64'(0));
    check("abort_write_data", 64'(o_register_write_data), 64'(0));
    i_rst = 1'b0; i_psel = 1'b0; i_penable = 1'b0;
    idle_cycles(2);
    t = rand_xfer(); t.active = 2'b10; t.delay = 0;
    do_xfer(t);

    // Randomized traffic, mixing back-to-back and gapped transfers.
    for (int n = 0; n < 60; n++) begin
      do_xfer(rand_xfer());
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end

    idle_cycles(4);
    check("responses_outstanding", 64'(rsp_q.size()), 64'(0));
    check("requests_outstanding", 64'(req_q.size()), 64'(0));
    check("pready_count", 64'(n_pready), 64'(n_issued));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rggen_apb_adapter.md
RGGEN_APB_ADAPTER -- requirements
Module: rggen_apb_adapter

Interface
REQ-001 SHALL provide parameter ADDRESS_WIDTH, default 8: byte-address width of bus and register-side address.
REQ-002 SHALL provide parameter BUS_WIDTH, default 32: data width; 32 or 64 only.
REQ-003 SHALL provide parameter REGISTERS, default 1: number of attached registers; at least 1.
REQ-004 SHALL use one clock and a synchronous, active-high reset; all state changes on the rising edge of i_clk.
REQ-005 SHALL provide the following ports (name, direction, width, meaning):
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_psel  in  1  APB select
i_penable  in  1  APB enable
i_paddr  in  ADDRESS_WIDTH  APB address
i_pwrite  in  1  1 = write
i_pwdata  in  BUS_WIDTH  write data
i_pstrb  in  BUS_WIDTH/8  byte strobes
o_pready  out  1  transfer done
o_prdata  out  BUS_WIDTH  read data
o_pslverr  out  1  error response
o_register_valid  out  1  request to registers
o_register_access  out  2  2'b00 read, 2'b01 write
o_register_address  out  ADDRESS_WIDTH  captured address
o_register_write_data  out  BUS_WIDTH  captured write data
o_register_strobe  out  BUS_WIDTH/8  captured strobes
i_register_active  in  REGISTERS  per-register address hit
i_register_ready  in  REGISTERS  per-register done
i_register_status  in  2*REGISTERS  per-register status: 00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR
i_register_read_data  in  BUS_WIDTH*REGISTERS  per-register read data

Function
REQ-006 SHALL implement states IDLE, BUSY, RESPONSE.
REQ-007 In IDLE, when i_psel=1 and i_penable=0, the block SHALL capture paddr, pwrite, pwdata and pstrb, and SHALL move to BUSY on the next edge.
REQ-008 In IDLE, the block SHALL ignore i_psel=1 with i_penable=1 (no capture).
REQ-009 o_register_valid SHALL be 1 only in BUSY; address, access, write_data and strobe SHALL hold their captured values while in BUSY.
REQ-010 For reads, o_register_strobe SHALL be all ones and o_register_write_data SHALL be zero.
REQ-011 In BUSY, the response condition SHALL be true when any (i_register_active & i_register_ready) bit is 1, or when i_register_active is all zero.
REQ-012 In BUSY, while the response condition is false, the block SHALL remain in BUSY with the request held, with no timeout.
REQ-013 When the response condition is true, on that edge the block SHALL latch the response into internal registers and move to RESPONSE:
- read data = OR over registers of (active & ready ? read_data : 0);
- status = the same OR-reduction of the per-register status.
REQ-014 An all-zero i_register_active SHALL produce status 2'b11 (decode error) and read data 0.
REQ-015 In RESPONSE, o_pready SHALL be 1 and o_pslverr SHALL equal latched status bit 1; o_prdata SHALL equal latched read data for reads and 0 for writes.
REQ-016 RESPONSE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 o_pready, o_pslverr and o_prdata SHALL be 0 in IDLE and BUSY.
REQ-018 Minimum latency SHALL be: setup at cycle T0, o_register_valid at T1, o_pready at T2 when the register is ready at T1.
REQ-019 Back-to-back transfers SHALL be allowed: a setup phase in the cycle after RESPONSE is captured normally.
REQ-020 Multiple simultaneous active bits are a system error; the OR-reduction result SHALL be returned without any further check.

Reset
REQ-021 While i_rst=1, state SHALL be IDLE, all outputs SHALL be 0, and all captured/latched registers SHALL be 0.
REQ-022 Reset asserted in BUSY or RESPONSE SHALL abandon the transfer with no o_pready pulse; the first cycle after reset SHALL be IDLE.

Verification
REQ-023 Write 0x12345678 to addr 0x04, strb 0xF; register 0 active and ready in BUSY with status 00 -> valid for 1 cycle, access 01, pready at T2, pslverr 0, prdata 0.
REQ-024 Read addr 0x08 with REGISTERS=2; register 1 active, ready after 3 BUSY cycles with data 0xCAFEF00D -> valid held 3 cycles, prdata 0xCAFEF00D, pslverr 0.
REQ-025 Read addr 0x3C with no active bits -> response after 1 BUSY cycle, pslverr 1, prdata 0.
REQ-026 Register returns status 10 on write -> pslverr 1 in RESPONSE.
REQ-027 Two back-to-back reads -> second setup captured the cycle after the first pready, with no lost or duplicated valid.
REQ-028 i_rst asserted during BUSY -> no pready, valid 0 on the next cycle, and the next transfer completes normally.
